fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I five-stage pipeline. It owns the PC, issues requests to instruction memory over a req/gnt/rvalid handshake, buffers returning instructions in a 2-entry queue, and drives the IF/ID pipeline register. It consumes the hazard unit's load-use `stall` and its branch/jump `flush` (PCSrc_E) with the redirect target.

---
 rtl/fetch_stage_pkg.sv | 30 +++
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage_queue.sv | 98 +++++++++
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared RV32I fetch definitions: data width, the canonical NOP
//            (addi x0,x0,0), default reset PC, the queue entry type and a
//            PC increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int QDEPTH = 2;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^32 without any flag.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-memory request/response bundle.
// Signals  : req    - request valid (fetch -> memory)
//            addr   - request address, held while req && !gnt
//            gnt    - request accepted this cycle (memory -> fetch)
//            rvalid - response valid, in order, >=1 cycle after grant
//            rdata  - instruction word returned with rvalid
// Modports : master (fetch stage), slave (instruction memory)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Two-entry FIFO of {instr, pc} plus a two-entry PC-tag FIFO that
//            pairs each in-order memory response with the address it was
//            requested from. Synchronous clear drops everything at once.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            clr_i          - synchronous clear of both FIFOs (wins)
//            tag_push_i/tag_i - record the PC of a granted request
//            rsp_i          - a kept (not dropped) response arrives; pops tag
//            rsp_instr_i    - instruction word of that response
//            bypass_i       - response goes straight to IF/ID, do not store
//            pop_i          - IF/ID consumes the head entry
//            rsp_pc_o       - PC tag belonging to the current response
//            head_o         - oldest buffered entry
//            count_o        - number of buffered entries (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            tag_push_i,
  input  logic [XLEN-1:0] tag_i,
  input  logic            rsp_i,
  input  logic [XLEN-1:0] rsp_instr_i,
  input  logic            bypass_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] rsp_pc_o,
  output fetch_entry_t    head_o,
  output logic [1:0]      count_o
);

  logic [XLEN-1:0] tag_mem_q [QDEPTH];
  logic            tag_wr_q;
  logic            tag_rd_q;

  fetch_entry_t    ent_q [QDEPTH];
  logic            ent_wr_q;
  logic            ent_rd_q;
  logic [1:0]      ent_cnt_q;
  logic [1:0]      ent_cnt_d;

  logic            ent_push;
  fetch_entry_t    rsp_entry;

  // Every kept response consumes a tag; only non-bypassed ones are stored.
  assign ent_push        = rsp_i && !bypass_i;
  assign rsp_pc_o        = tag_mem_q[tag_rd_q];
  assign rsp_entry.instr = rsp_instr_i;
  assign rsp_entry.pc    = rsp_pc_o;

  assign ent_cnt_d = ent_cnt_q + {1'b0, ent_push} - {1'b0, pop_i};

  assign head_o  = ent_q[ent_rd_q];
  assign count_o = ent_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_q  <= 1'b0;
      tag_rd_q  <= 1'b0;
      ent_wr_q  <= 1'b0;
      ent_rd_q  <= 1'b0;
      ent_cnt_q <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        tag_mem_q[i] <= '0;
        ent_q[i]     <= '0;
      end
    end else if (clr_i) begin
      // Storage contents are left as-is; only pointers and count matter.
      tag_wr_q  <= 1'b0;
      tag_rd_q  <= 1'b0;
      ent_wr_q  <= 1'b0;
      ent_rd_q  <= 1'b0;
      ent_cnt_q <= 2'd0;
    end else begin
      if (tag_push_i) begin
        tag_mem_q[tag_wr_q] <= tag_i;
        tag_wr_q            <= ~tag_wr_q;
      end
      if (rsp_i) begin
        tag_rd_q <= ~tag_rd_q;
      end
      if (ent_push) begin
        ent_q[ent_wr_q] <= rsp_entry;
        ent_wr_q        <= ~ent_wr_q;
      end
      if (pop_i) begin
        ent_rd_q <= ~ent_rd_q;
      end
      ent_cnt_q <= ent_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32I instruction-fetch stage. Owns PC_F, issues credit-limited
//            requests to instruction memory, buffers responses in a 2-entry
//            queue (with a same-cycle bypass) and drives the IF/ID register.
//            Honours load-use stall and branch/jump flush with redirect.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            stall           - hold IF/ID contents (load-use)
//            flush           - redirect to PCTarget_E, discard wrong path
//            PCTarget_E      - redirect address, valid with flush
//            imem            - instruction memory req/gnt/rvalid bundle
//            instr_D, PC_D, PCPlus4_D, valid_D - IF/ID register outputs
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] PCTarget_E,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] instr_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
  output logic            valid_D
);

  // Fetch PC and transaction accounting
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [1:0]      osd_q, osd_d;     // requests granted, response not yet seen
  logic [1:0]      drop_q, drop_d;   // of those, how many are wrong-path

  // IF/ID register
  fetch_entry_t    ifid_q, ifid_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            if_valid_q, if_valid_d;

  // Queue side
  logic [1:0]      q_count;
  logic            q_empty;
  fetch_entry_t    q_head;
  logic [XLEN-1:0] rsp_pc;

  logic            req;
  logic            grant;
  logic            resp;
  logic            resp_keep;
  logic            resp_drop;
  logic            if_load;
  logic            bypass;
  logic            q_pop;

  // Credit: at most two instructions may be in flight or buffered. The sum
  // is taken one bit wider so 2+2 cannot alias to a small value.
  assign req = rst_n && !flush &&
               (({1'b0, osd_q} + {1'b0, q_count}) < 3'd2);

  assign grant = req && imem.gnt;

  // A response with nothing outstanding is a protocol violation; ignore it.
  assign resp      = imem.rvalid && (osd_q != 2'd0);
  assign resp_drop = resp && (drop_q != 2'd0);
  assign resp_keep = resp && (drop_q == 2'd0);

  assign q_empty = (q_count == 2'd0);
  assign if_load = !if_valid_q || !stall;

  // A kept response skips the queue only when nothing older is buffered,
  // otherwise ordering would break.
  assign bypass = resp_keep && q_empty && if_load && !flush;
  assign q_pop  = if_load && !q_empty && !flush;

  fetch_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush),
    .tag_push_i  (grant),
    .tag_i       (pc_f_q),
    .rsp_i       (resp_keep),
    .rsp_instr_i (imem.rdata),
    .bypass_i    (bypass),
    .pop_i       (q_pop),
    .rsp_pc_o    (rsp_pc),
    .head_o      (q_head),
    .count_o     (q_count)
  );

  // PC and counters
  always_comb begin
    pc_f_d = pc_f_q;
    osd_d  = osd_q + {1'b0, grant} - {1'b0, resp};
    drop_d = drop_q - {1'b0, resp_drop};

    if (flush) begin
      pc_f_d = PCTarget_E;
      // Everything still in flight after this cycle's response is wrong-path.
      // No grant can occur in a flush cycle, so osd_d is exactly that count.
      drop_d = osd_d;
    end else if (grant) begin
      pc_f_d = pc_plus4(pc_f_q);
    end
  end

  // IF/ID next state. On a bubble the PC fields keep their old value; only
  // valid_D and the NOP word are meaningful then.
  always_comb begin
    ifid_d     = ifid_q;
    pc4_d      = pc4_q;
    if_valid_d = if_valid_q;

    if (flush) begin
      ifid_d.instr = NOP_INSTR;
      if_valid_d   = 1'b0;
    end else if (if_load) begin
      if (!q_empty) begin
        ifid_d     = q_head;
        pc4_d      = pc_plus4(q_head.pc);
        if_valid_d = 1'b1;
      end else if (resp_keep) begin
        ifid_d.instr = imem.rdata;
        ifid_d.pc    = rsp_pc;
        pc4_d        = pc_plus4(rsp_pc);
        if_valid_d   = 1'b1;
      end else begin
        ifid_d.instr = NOP_INSTR;
        if_valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q       <= RESET_PC;
      osd_q        <= 2'd0;
      drop_q       <= 2'd0;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc    <= '0;
      pc4_q        <= '0;
      if_valid_q   <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      osd_q      <= osd_d;
      drop_q     <= drop_d;
      ifid_q     <= ifid_d;
      pc4_q      <= pc4_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem.req  = req;
  assign imem.addr = pc_f_q;

  assign instr_D   = ifid_q.instr;
  assign PC_D      = ifid_q.pc;
  assign PCPlus4_D = pc4_q;
  assign valid_D   = if_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed and randomised checks of fetch_stage against a
//            behavioural instruction memory with configurable latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] PCTarget_E = '0;
  logic [31:0] instr_D, PC_D, PCPlus4_D;
  logic        valid_D;

  fetch_stage_if imem_bus();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .PCTarget_E (PCTarget_E),
    .imem       (imem_bus),
    .instr_D    (instr_D),
    .PC_D       (PC_D),
    .PCPlus4_D  (PCPlus4_D),
    .valid_D    (valid_D)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- memory model ----------------
  int          gnt_lat_cfg = 0;
  int          rsp_lat_cfg = 1;
  bit          rand_mode = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_cnt[$];
  int          gwait = 0;
  bit          mem_wait = 1'b0;
  logic [31:0] mem_wait_addr = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Outputs are decided just after the falling edge; the handshake that
  // actually happened is recorded just before the next rising edge.
  initial begin
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend_addr.delete();
        pend_cnt.delete();
        gwait = 0;
        mem_wait = 1'b0;
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
      end else begin
        imem_bus.gnt = (gwait == 0);
        if (pend_cnt.size() > 0 && pend_cnt[0] == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = instr_of(pend_addr[0]);
        end else begin
          imem_bus.rvalid = 1'b0;
          imem_bus.rdata  = 32'hDEAD_BEEF;
        end
        #3;
        if (imem_bus.rvalid) begin
          void'(pend_addr.pop_front());
          void'(pend_cnt.pop_front());
        end
        foreach (pend_cnt[i]) if (pend_cnt[i] > 0) pend_cnt[i] = pend_cnt[i] - 1;
        mem_wait      = imem_bus.req && !imem_bus.gnt;
        mem_wait_addr = imem_bus.addr;
        if (imem_bus.req && imem_bus.gnt) begin
          pend_addr.push_back(imem_bus.addr);
          pend_cnt.push_back((rand_mode ? int'($urandom_range(1, 4)) : rsp_lat_cfg) - 1);
          gwait = rand_mode ? int'($urandom_range(0, 3)) : gnt_lat_cfg;
        end else if (imem_bus.req && gwait > 0) begin
          gwait = gwait - 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 2 time units into the first cycle after release (c0).
  task automatic do_reset(input int gl, input int rl, input bit rm);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; PCTarget_E = '0;
    gnt_lat_cfg = gl; rsp_lat_cfg = rl; rand_mode = rm;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_vec++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_D); end
    n_vec++; if (instr_D !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", instr_D); end
    n_vec++; if (PC_D !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", PC_D); end
    n_vec++; if (PCPlus4_D !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", PCPlus4_D); end
    n_vec++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_bus.req); end
  endtask

  // Zero-wait memory; ends in c6 with PC 0x10 in IF/ID.
  task automatic test_stream();
    do_reset(0, 1, 1'b0);
    n_vec++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin n_fail++; $display("FAIL stream_c0_req: req=%b addr=%h want 1/0", imem_bus.req, imem_bus.addr); end
    step();
    n_vec++; if (imem_bus.addr !== 32'h4) begin n_fail++; $display("FAIL stream_c1_addr: got %h want 4", imem_bus.addr); end
    n_vec++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %b want 0", valid_D); end
    step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h0) begin n_fail++; $display("FAIL stream_first: valid=%b pc=%h want 1/0", valid_D, PC_D); end
    n_vec++; if (instr_D !== 32'hC0DE_0000) begin n_fail++; $display("FAIL stream_first_instr: got %h want c0de0000", instr_D); end
    n_vec++; if (PCPlus4_D !== 32'h4) begin n_fail++; $display("FAIL stream_first_pc4: got %h want 4", PCPlus4_D); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_seq%0d: valid=%b pc=%h want 1/%h", k, valid_D, PC_D, 32'(4 * k)); end
    end
  endtask

  // Continues from test_stream: 0x10 is in IF/ID.
  task automatic test_stall();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h14; exp_seq[1] = 32'h18; exp_seq[2] = 32'h1C;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h10) begin n_fail++; $display("FAIL stall_hold%0d: valid=%b pc=%h want 1/10", i, valid_D, PC_D); end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (valid_D !== 1'b1 || PC_D !== exp_seq[i] || instr_D !== instr_of(exp_seq[i])) begin
        n_fail++; $display("FAIL stall_resume%0d: valid=%b pc=%h instr=%h want pc %h", i, valid_D, PC_D, instr_D, exp_seq[i]);
      end
    end
  endtask

  // Two-cycle memory; flush in c5 with requests for 0x8 and 0xC in flight.
  task automatic test_flush_drop();
    do_reset(0, 2, 1'b0);
    step(); step(); step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h0) begin n_fail++; $display("FAIL fdrop_c3: valid=%b pc=%h want 1/0", valid_D, PC_D); end
    step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h4) begin n_fail++; $display("FAIL fdrop_c4: valid=%b pc=%h want 1/4", valid_D, PC_D); end
    step();
    n_vec++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL fdrop_c5_valid: got %b want 0", valid_D); end
    flush = 1'b1; PCTarget_E = 32'h100;
    #1;
    n_vec++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL fdrop_flush_req: got %b want 0", imem_bus.req); end
    step();
    flush = 1'b0;
    #1;
    n_vec++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100) begin n_fail++; $display("FAIL fdrop_redirect: req=%b addr=%h want 1/100", imem_bus.req, imem_bus.addr); end
    for (int i = 6; i <= 8; i++) begin
      n_vec++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL fdrop_bubble_c%0d: valid=%b pc=%h want 0", i, valid_D, PC_D); end
      step();
    end
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h100 || instr_D !== instr_of(32'h100)) begin n_fail++; $display("FAIL fdrop_target: valid=%b pc=%h instr=%h want 1/100", valid_D, PC_D, instr_D); end
    step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h104) begin n_fail++; $display("FAIL fdrop_next: valid=%b pc=%h want 1/104", valid_D, PC_D); end
  endtask

  task automatic test_flush_stall();
    do_reset(0, 1, 1'b0);
    step(); step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h0) begin n_fail++; $display("FAIL fstall_pre: valid=%b pc=%h want 1/0", valid_D, PC_D); end
    flush = 1'b1; stall = 1'b1; PCTarget_E = 32'h200;
    #1;
    n_vec++; if (imem_bus.req !== 1'b0) begin n_fail++; $display("FAIL fstall_req: got %b want 0", imem_bus.req); end
    step();
    n_vec++; if (valid_D !== 1'b0 || instr_D !== 32'h0000_0013) begin n_fail++; $display("FAIL fstall_bubble: valid=%b instr=%h want 0/00000013", valid_D, instr_D); end
    flush = 1'b0; stall = 1'b0;
    #1;
    n_vec++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h200) begin n_fail++; $display("FAIL fstall_redirect: req=%b addr=%h want 1/200", imem_bus.req, imem_bus.addr); end
    step();
    n_vec++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL fstall_c4: valid=%b want 0", valid_D); end
    step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h200) begin n_fail++; $display("FAIL fstall_target: valid=%b pc=%h want 1/200", valid_D, PC_D); end
    step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h204) begin n_fail++; $display("FAIL fstall_next: valid=%b pc=%h want 1/204", valid_D, PC_D); end
  endtask

  task automatic test_wrap();
    do_reset(0, 1, 1'b0);
    step(); step();
    flush = 1'b1; PCTarget_E = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    #1;
    n_vec++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req_top: req=%b addr=%h want 1/fffffffc", imem_bus.req, imem_bus.addr); end
    step();
    n_vec++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin n_fail++; $display("FAIL wrap_req_zero: req=%b addr=%h want 1/0", imem_bus.req, imem_bus.addr); end
    step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'hFFFF_FFFC || PCPlus4_D !== 32'h0) begin n_fail++; $display("FAIL wrap_top: valid=%b pc=%h pc4=%h want 1/fffffffc/0", valid_D, PC_D, PCPlus4_D); end
    step();
    n_vec++; if (valid_D !== 1'b1 || PC_D !== 32'h0 || PCPlus4_D !== 32'h4) begin n_fail++; $display("FAIL wrap_zero: valid=%b pc=%h pc4=%h want 1/0/4", valid_D, PC_D, PCPlus4_D); end
  endtask

  // Random grant/response delays, stalls and flushes.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] prev_pc = 32'h0;
    bit prev_valid = 1'b0, prev_stall = 1'b0, prev_flush = 1'b0;
    int seen = 0, cycles = 0;
    do_reset(0, 1, 1'b1);
    while (seen < 5000 && cycles < 40000) begin
      if (prev_flush) begin
        n_vec++; if (valid_D !== 1'b0) begin n_fail++; $display("FAIL rand_flush_bubble: valid=%b pc=%h want 0", valid_D, PC_D); end
      end else if (prev_valid && prev_stall) begin
        n_vec++; if (valid_D !== 1'b1 || PC_D !== prev_pc) begin n_fail++; $display("FAIL rand_hold: valid=%b pc=%h want 1/%h", valid_D, PC_D, prev_pc); end
      end else if (valid_D === 1'b1) begin
        n_vec++; if (PC_D !== exp_pc || instr_D !== instr_of(exp_pc)) begin n_fail++; $display("FAIL rand_seq: pc=%h instr=%h want pc %h", PC_D, instr_D, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
      n_vec++; if (pend_addr.size() > 2) begin n_fail++; $display("FAIL rand_credit: in flight %0d want <=2", pend_addr.size()); end
      prev_valid = (valid_D === 1'b1);
      prev_pc    = PC_D;
      flush = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 20);
      if (flush) begin
        PCTarget_E = 32'h1000 + 32'($urandom_range(0, 255) << 2);
        exp_pc = PCTarget_E;
      end
      prev_stall = stall;
      prev_flush = flush;
      #1;
      if (!flush && mem_wait) begin
        n_vec++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== mem_wait_addr) begin n_fail++; $display("FAIL rand_addr_hold: req=%b addr=%h want 1/%h", imem_bus.req, imem_bus.addr, mem_wait_addr); end
      end
      step();
      cycles++;
    end
    n_vec++; if (seen < 5000) begin n_fail++; $display("FAIL rand_timeout: %0d instructions seen want 5000", seen); end
    flush = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_drop();
    test_flush_stall();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
